// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU-control package for the hazard controller and its memory-port arbiter.
// Holds the arbiter state encoding, the arbitration-mode constants and the
// last-conflict-winner encoding used for round-robin arbitration.
package hazard_ctrl_pkg;

    // Owner of the shared instruction/data memory port.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_OWN  = 2'd1,
        ARB_MEM_OWN = 2'd2
    } arb_state_e;

    // Which port won the most recent fetch/data conflict.
    typedef enum logic {
        LAST_IF  = 1'b0,
        LAST_MEM = 1'b1
    } arb_last_e;

    // Arbitration policies for simultaneous fetch and data requests.
    localparam int ARB_MEM_PRIO    = 0;  // data port always wins
    localparam int ARB_ROUND_ROBIN = 1;  // alternate winners between conflicts

endpackage

// File: rtl/mem_port_arb.sv
// Arbiter for the memory port shared by instruction fetch and data access.
// Grants are combinational (same cycle as the request); the owner FSM and the
// last-conflict-winner register are updated on the clock edge.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   kill                suppress all grants and return the FSM to idle
//   if_req, mem_req     fetch / data requests
//   grant_if, grant_mem one-hot-or-zero grants
//   if_lose, mem_lose   the named requester lost a conflict this cycle
module mem_port_arb
    import hazard_ctrl_pkg::*;
#(
    parameter int ARB_MODE = ARB_MEM_PRIO
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kill,
    input  logic if_req,
    input  logic mem_req,
    output logic grant_if,
    output logic grant_mem,
    output logic if_lose,
    output logic mem_lose
);

    arb_state_e state_reg;
    arb_last_e  last_reg;
    logic       conflict;
    logic       mem_wins;
    logic       state_unused;

    assign conflict = if_req & mem_req;

    // Round-robin hands the conflict to whichever port lost the previous one;
    // last_reg starts at IF so the first conflict goes to the data port.
    assign mem_wins = (ARB_MODE == ARB_MEM_PRIO) ? 1'b1 : (last_reg == LAST_IF);

    assign grant_mem = ~kill & mem_req & (~if_req | mem_wins);
    assign grant_if  = ~kill & if_req & (~mem_req | ~mem_wins);
    assign if_lose   = ~kill & conflict & mem_wins;
    assign mem_lose  = ~kill & conflict & ~mem_wins;

    // The owner state records who holds the port for probing/debug; the
    // grants themselves never depend on it.
    assign state_unused = ^state_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ARB_IDLE;
            last_reg  <= LAST_IF;
        end else if (kill) begin
            state_reg <= ARB_IDLE;
        end else begin
            if (grant_mem) begin
                state_reg <= ARB_MEM_OWN;
            end else if (grant_if) begin
                state_reg <= ARB_IF_OWN;
            end else begin
                state_reg <= ARB_IDLE;
            end
            if (conflict) begin
                last_reg <= grant_mem ? LAST_MEM : LAST_IF;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: merges external stall requests, load-use
// interlock, shared-memory-port conflicts, branch redirects and exception
// flushes into per-register stall/flush controls.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall_req[STAGES]           external stall request from stage i
//   ex_load, ex_rd              load in ID/EX and its destination register
//   id_rs, id_rt                ID source registers
//   id_use_rs, id_use_rt        source actually read
//   redirect                    taken branch/jump resolved in ID
//   exc_flush                   exception/eret, kill everything in flight
//   if_req, mem_req             shared memory port requests
//   stall[STAGES], flush[STAGES] pipeline register controls (flush[0] = 0)
//   grant_if, grant_mem         shared memory port grants
//   stall_cycles                saturating count of cycles with stall[0]
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int STAGES     = 5,
    parameter int MEM_STAGE  = 3,
    parameter int LU_BUBBLES = 1,
    parameter int ARB_MODE   = ARB_MEM_PRIO
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STAGES-1:0] stall_req,
    input  logic              ex_load,
    input  logic [4:0]        ex_rd,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              redirect,
    input  logic              exc_flush,
    input  logic              if_req,
    input  logic              mem_req,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] flush,
    output logic              grant_if,
    output logic              grant_mem,
    output logic [31:0]       stall_cycles
);

    localparam int             CNT_W   = 2;
    localparam logic [CNT_W-1:0] LU_LOAD = CNT_W'(LU_BUBBLES - 1);

    logic              lu_hit;
    logic              lu_stall;
    logic              bubble_freeze;
    logic              arb_kill;
    logic              if_lose;
    logic              mem_lose;
    logic [CNT_W-1:0]  bubble_cnt_reg;
    logic [CNT_W-1:0]  bubble_cnt_next;
    logic [STAGES-1:0] stall_src;
    logic [STAGES-1:0] stall_raw;
    logic [31:0]       stall_cycles_reg;

    // Register 0 never matches a real dependency.
    assign lu_hit = ex_load & (ex_rd != 5'd0) &
                    ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

    assign lu_stall      = lu_hit | (bubble_cnt_reg != '0);
    assign bubble_freeze = |stall_req[STAGES-1:2];
    assign arb_kill      = exc_flush | ~rst_n;

    mem_port_arb #(
        .ARB_MODE(ARB_MODE)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .kill     (arb_kill),
        .if_req   (if_req),
        .mem_req  (mem_req),
        .grant_if (grant_if),
        .grant_mem(grant_mem),
        .if_lose  (if_lose),
        .mem_lose (mem_lose)
    );

    // Every stall source names the deepest register it must hold; everything
    // upstream of the deepest one holds too, so stall_raw is a low-side mask.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stall
            assign stall_src[gi] = stall_req[gi]
                                 | ((gi == 0)         ? if_lose  : 1'b0)
                                 | ((gi == 1)         ? lu_stall : 1'b0)
                                 | ((gi == MEM_STAGE) ? mem_lose : 1'b0);
            assign stall_raw[gi] = |stall_src[STAGES-1:gi];
            assign stall[gi]     = rst_n & ~exc_flush & stall_raw[gi];
        end
    endgenerate

    // A bubble enters just past the deepest held register. A redirect only
    // kills the ID register when it is free to advance; a held ID re-presents
    // the branch later.
    assign flush[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_flush
            assign flush[gi] = rst_n & (exc_flush
                             | (stall_raw[gi-1] & ~stall_raw[gi])
                             | ((gi == 1) ? (redirect & ~stall_raw[1]) : 1'b0));
        end
    endgenerate

    // Remaining load-use bubbles beyond the first; held while a downstream
    // stall keeps the bubble from advancing.
    always_comb begin
        bubble_cnt_next = bubble_cnt_reg;
        if (exc_flush) begin
            bubble_cnt_next = '0;
        end else if (lu_hit) begin
            bubble_cnt_next = LU_LOAD;
        end else if ((bubble_cnt_reg != '0) && !bubble_freeze) begin
            bubble_cnt_next = bubble_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_reg   <= '0;
            stall_cycles_reg <= '0;
        end else begin
            bubble_cnt_reg <= bubble_cnt_next;
            if (stall[0] && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int NI = 3;
    localparam int LU_P[NI]   = '{1, 2, 1};
    localparam int MODE_P[NI] = '{0, 0, 1};
    localparam int MEM_P = 3;

    logic       clk;
    logic       rst_n;
    logic [4:0] stall_req;
    logic       ex_load;
    logic [4:0] ex_rd, id_rs, id_rt;
    logic       id_use_rs, id_use_rt, redirect, exc_flush, if_req, mem_req;

    logic [4:0]  st_o[NI];
    logic [4:0]  fl_o[NI];
    logic        gi_o[NI];
    logic        gm_o[NI];
    logic [31:0] sc_o[NI];

    int n_chk;
    int n_fail;

    // Reference model state, one entry per instance.
    int          bub[NI];
    bit          last_mem[NI];
    logic [31:0] scnt[NI];

    hazard_ctrl #(.STAGES(5), .MEM_STAGE(3), .LU_BUBBLES(1), .ARB_MODE(0)) u_def (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .ex_load(ex_load), .ex_rd(ex_rd),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .redirect(redirect), .exc_flush(exc_flush), .if_req(if_req), .mem_req(mem_req),
        .stall(st_o[0]), .flush(fl_o[0]), .grant_if(gi_o[0]), .grant_mem(gm_o[0]),
        .stall_cycles(sc_o[0]));

    hazard_ctrl #(.STAGES(5), .MEM_STAGE(3), .LU_BUBBLES(2), .ARB_MODE(0)) u_lu2 (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .ex_load(ex_load), .ex_rd(ex_rd),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .redirect(redirect), .exc_flush(exc_flush), .if_req(if_req), .mem_req(mem_req),
        .stall(st_o[1]), .flush(fl_o[1]), .grant_if(gi_o[1]), .grant_mem(gm_o[1]),
        .stall_cycles(sc_o[1]));

    hazard_ctrl #(.STAGES(5), .MEM_STAGE(3), .LU_BUBBLES(1), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .ex_load(ex_load), .ex_rd(ex_rd),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .redirect(redirect), .exc_flush(exc_flush), .if_req(if_req), .mem_req(mem_req),
        .stall(st_o[2]), .flush(fl_o[2]), .grant_if(gi_o[2]), .grant_mem(gm_o[2]),
        .stall_cycles(sc_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] sreq;
        logic       ld;
        logic [4:0] rd, rs, rt;
        logic       urs, urt, redir, exc, ifr, memr;
        logic [4:0] es, ef;
        logic       gif, gmem;
    } vec_t;

    vec_t tv[17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        stall_req = '0; ex_load = 0; ex_rd = '0; id_rs = '0; id_rt = '0;
        id_use_rs = 0; id_use_rt = 0; redirect = 0; exc_flush = 0; if_req = 0; mem_req = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NI; k++) begin
            bub[k] = 0; last_mem[k] = 0; scnt[k] = '0;
        end
    endtask

    function automatic bit model_hit();
        return ex_load && (ex_rd != 0) &&
               ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    endfunction

    // Deepest held register decides everything: all registers up to it hold,
    // the one right after it takes a bubble.
    task automatic model_out(input int k, output logic [4:0] es, output logic [4:0] ef,
                             output logic eg_if, output logic eg_mem);
        int depth;
        bit conflict, mem_wins;
        depth = -1;
        for (int i = 0; i < 5; i++) if (stall_req[i]) depth = i;
        if ((model_hit() || bub[k] > 0) && depth < 1) depth = 1;
        conflict = if_req && mem_req;
        mem_wins = (MODE_P[k] == 0) || !last_mem[k];
        eg_if  = if_req && !(conflict && mem_wins);
        eg_mem = mem_req && !(conflict && !mem_wins);
        if (conflict) begin
            if (mem_wins) begin
                if (depth < 0) depth = 0;
            end else begin
                if (depth < MEM_P) depth = MEM_P;
            end
        end
        es = (depth < 0) ? 5'd0 : 5'((1 << (depth + 1)) - 1);
        ef = (depth >= 0 && depth < 4) ? 5'(1 << (depth + 1)) : 5'd0;
        if (redirect && !es[1]) ef[1] = 1'b1;
        if (exc_flush) begin
            es = 5'd0; ef = 5'b11110; eg_if = 0; eg_mem = 0;
        end
    endtask

    task automatic model_step(input int k, input logic stall0);
        bit conflict, mem_wins;
        conflict = if_req && mem_req;
        mem_wins = (MODE_P[k] == 0) || !last_mem[k];
        if (exc_flush) bub[k] = 0;
        else if (model_hit()) bub[k] = LU_P[k] - 1;
        else if (bub[k] > 0 && stall_req[4:2] == 3'b000) bub[k] = bub[k] - 1;
        if (!exc_flush && conflict) last_mem[k] = mem_wins;
        if (stall0 && scnt[k] != 32'hFFFF_FFFF) scnt[k] = scnt[k] + 1;
    endtask

    initial begin
        logic [4:0]  es, ef;
        logic        eg_if, eg_mem;
        logic [31:0] exp_sc;
        n_chk = 0;
        n_fail = 0;

        // ---------------- reset state with busy inputs ----------------
        rst_n = 1'b0;
        clear_inputs();
        stall_req = 5'b11111; if_req = 1; mem_req = 1; redirect = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_stall_u%0d", k), 32'(st_o[k]), 32'd0);
            check($sformatf("rst_flush_u%0d", k), 32'(fl_o[k]), 32'd0);
            check($sformatf("rst_grants_u%0d", k), {30'd0, gi_o[k], gm_o[k]}, 32'd0);
            check($sformatf("rst_sc_u%0d", k), sc_o[k], 32'd0);
        end
        $display("reset: outputs checked while rst_n=0");

        // ---------------- table vectors on default instance ----------------
        tv[0]  = '{5'b01000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01111, 5'b10000, 0, 0};
        tv[1]  = '{5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0};
        tv[2]  = '{5'b10000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0};
        tv[3]  = '{5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 5'b00010, 0, 0};
        tv[4]  = '{5'b00000, 1, 8, 8, 0, 1, 0, 0, 0, 0, 0, 5'b00011, 5'b00100, 0, 0};
        tv[5]  = '{5'b00000, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0};
        tv[6]  = '{5'b00000, 1, 5, 0, 5, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0};
        tv[7]  = '{5'b00000, 1, 5, 0, 5, 0, 1, 0, 0, 0, 0, 5'b00011, 5'b00100, 0, 0};
        tv[8]  = '{5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 1, 0};
        tv[9]  = '{5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 0, 1};
        tv[10] = '{5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00001, 5'b00010, 0, 1};
        tv[11] = '{5'b00000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00000, 5'b00010, 0, 0};
        tv[12] = '{5'b00010, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00011, 5'b00100, 0, 0};
        tv[13] = '{5'b00100, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00000, 5'b11110, 0, 0};
        tv[14] = '{5'b00100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00111, 5'b01000, 0, 1};
        tv[15] = '{5'b00000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 5'b00001, 5'b00010, 0, 1};
        tv[16] = '{5'b00000, 1, 8, 8, 3, 0, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0};

        reset_all();
        exp_sc = 32'd0;
        for (int v = 0; v < 17; v++) begin
            step();
            stall_req = tv[v].sreq; ex_load = tv[v].ld; ex_rd = tv[v].rd;
            id_rs = tv[v].rs; id_rt = tv[v].rt; id_use_rs = tv[v].urs; id_use_rt = tv[v].urt;
            redirect = tv[v].redir; exc_flush = tv[v].exc; if_req = tv[v].ifr; mem_req = tv[v].memr;
            @(negedge clk);
            check($sformatf("tv%0d_stall", v), 32'(st_o[0]), 32'(tv[v].es));
            check($sformatf("tv%0d_flush", v), 32'(fl_o[0]), 32'(tv[v].ef));
            check($sformatf("tv%0d_gif", v), 32'(gi_o[0]), 32'(tv[v].gif));
            check($sformatf("tv%0d_gmem", v), 32'(gm_o[0]), 32'(tv[v].gmem));
            check($sformatf("tv%0d_sc", v), sc_o[0], exp_sc);
            $display("vec %0d: sreq=%b stall=%b flush=%b gif=%b gmem=%b sc=%0d",
                     v, stall_req, st_o[0], fl_o[0], gi_o[0], gm_o[0], sc_o[0]);
            if (tv[v].es[0]) exp_sc = exp_sc + 1;
        end
        step();
        clear_inputs();
        @(negedge clk);
        check("tv_final_sc", sc_o[0], exp_sc);

        // ---------------- randomized run against the model ----------------
        reset_all();
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < 5; i++) stall_req[i] = ($urandom_range(0, 7) == 0);
            ex_load   = $urandom_range(0, 1) == 1;
            ex_rd     = 5'($urandom_range(0, 3));
            id_rs     = 5'($urandom_range(0, 3));
            id_rt     = 5'($urandom_range(0, 3));
            id_use_rs = $urandom_range(0, 1) == 1;
            id_use_rt = $urandom_range(0, 1) == 1;
            redirect  = $urandom_range(0, 3) == 0;
            exc_flush = $urandom_range(0, 15) == 0;
            if_req    = $urandom_range(0, 1) == 1;
            mem_req   = $urandom_range(0, 1) == 1;
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                model_out(k, es, ef, eg_if, eg_mem);
                check($sformatf("rnd%0d_stall_u%0d", c, k), 32'(st_o[k]), 32'(es));
                check($sformatf("rnd%0d_flush_u%0d", c, k), 32'(fl_o[k]), 32'(ef));
                check($sformatf("rnd%0d_gif_u%0d", c, k), 32'(gi_o[k]), 32'(eg_if));
                check($sformatf("rnd%0d_gmem_u%0d", c, k), 32'(gm_o[k]), 32'(eg_mem));
                check($sformatf("rnd%0d_sc_u%0d", c, k), sc_o[k], scnt[k]);
                model_step(k, es[0]);
            end
            $display("rnd %0d: sreq=%b ld=%b rd=%0d exc=%b req=%b%b stall=%b/%b/%b",
                     c, stall_req, ex_load, ex_rd, exc_flush, if_req, mem_req,
                     st_o[0], st_o[1], st_o[2]);
        end

        // ---------------- load-use with two bubbles ----------------
        reset_all();
        step();
        ex_load = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
        @(negedge clk);
        check("lu2_c1_stall", 32'(st_o[1]), 32'b00011);
        check("lu2_c1_flush", 32'(fl_o[1]), 32'b00100);
        $display("lu2 c1: stall=%b flush=%b", st_o[1], fl_o[1]);
        step();
        clear_inputs();
        @(negedge clk);
        check("lu2_c2_stall", 32'(st_o[1]), 32'b00011);
        check("lu2_c2_flush", 32'(fl_o[1]), 32'b00100);
        $display("lu2 c2: stall=%b flush=%b", st_o[1], fl_o[1]);
        step();
        @(negedge clk);
        check("lu2_c3_stall", 32'(st_o[1]), 32'b00000);
        check("lu2_c3_flush", 32'(fl_o[1]), 32'b00000);
        $display("lu2 c3: stall=%b flush=%b", st_o[1], fl_o[1]);

        // ---------------- round-robin conflict sequence ----------------
        reset_all();
        for (int c = 0; c < 3; c++) begin
            step();
            if_req = 1; mem_req = 1;
            @(negedge clk);
            check($sformatf("rr_c%0d_gmem", c + 1), 32'(gm_o[2]), (c == 1) ? 32'd0 : 32'd1);
            check($sformatf("rr_c%0d_gif", c + 1), 32'(gi_o[2]), (c == 1) ? 32'd1 : 32'd0);
            check($sformatf("rr_c%0d_flush", c + 1), 32'(fl_o[2]),
                  (c == 1) ? 32'b10000 : 32'b00010);
            check($sformatf("rr_c%0d_stall", c + 1), 32'(st_o[2]),
                  (c == 1) ? 32'b01111 : 32'b00001);
            $display("rr c%0d: gif=%b gmem=%b stall=%b flush=%b",
                     c + 1, gi_o[2], gm_o[2], st_o[2], fl_o[2]);
        end

        // ---------------- redirect blocked by load-use, then taken ----------------
        reset_all();
        step();
        ex_load = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1; redirect = 1;
        @(negedge clk);
        check("redir_c1_flush", 32'(fl_o[0]), 32'b00100);
        check("redir_c1_stall", 32'(st_o[0]), 32'b00011);
        $display("redir c1: stall=%b flush=%b", st_o[0], fl_o[0]);
        step();
        ex_load = 0;
        @(negedge clk);
        check("redir_c2_flush", 32'(fl_o[0]), 32'b00010);
        check("redir_c2_stall", 32'(st_o[0]), 32'b00000);
        $display("redir c2: stall=%b flush=%b", st_o[0], fl_o[0]);

        // ---------------- exception over stall and pending bubble ----------------
        reset_all();
        step();
        ex_load = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
        @(negedge clk);
        check("exc_c1_stall", 32'(st_o[1]), 32'b00011);
        step();
        clear_inputs();
        exc_flush = 1; stall_req = 5'b00100;
        @(negedge clk);
        check("exc_c2_flush", 32'(fl_o[1]), 32'b11110);
        check("exc_c2_stall", 32'(st_o[1]), 32'b00000);
        $display("exc c2: stall=%b flush=%b", st_o[1], fl_o[1]);
        step();
        clear_inputs();
        @(negedge clk);
        check("exc_c3_stall", 32'(st_o[1]), 32'b00000);
        check("exc_c3_flush", 32'(fl_o[1]), 32'b00000);
        $display("exc c3: stall=%b flush=%b", st_o[1], fl_o[1]);

        // ---------------- counter saturation and mid-conflict reset ----------------
        reset_all();
        step();
        force u_rr.stall_cycles_reg = 32'hFFFF_FFFE;
        #1;
        release u_rr.stall_cycles_reg;
        stall_req = 5'b00001;
        @(negedge clk);
        check("sat_preset", sc_o[2], 32'hFFFF_FFFE);
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            check($sformatf("sat_c%0d", c + 1), sc_o[2], 32'hFFFF_FFFF);
            $display("sat c%0d: stall_cycles=0x%08h", c + 1, sc_o[2]);
        end
        step();
        clear_inputs();
        if_req = 1; mem_req = 1;
        @(negedge clk);
        check("midrst_pre_gmem", 32'(gm_o[2]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_stall", 32'(st_o[2]), 32'd0);
        check("midrst_flush", 32'(fl_o[2]), 32'd0);
        check("midrst_grants", {30'd0, gi_o[2], gm_o[2]}, 32'd0);
        check("midrst_sc", sc_o[2], 32'd0);
        $display("midrst: stall=%b flush=%b gif=%b gmem=%b sc=%0d",
                 st_o[2], fl_o[2], gi_o[2], gm_o[2], sc_o[2]);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 5, meaning number of pipeline registers (bit 0 = PC, bit i = register in front of stage i); legal 4..8.
REQ-002 SHALL have parameter MEM_STAGE, default 3, meaning index of the data-memory stage; legal 2..STAGES-1.
REQ-003 SHALL have parameter LU_BUBBLES, default 1, meaning load-use bubble count; legal 1..3.
REQ-004 SHALL have parameter ARB_MODE, default 0, meaning shared-memory arbitration (0 = data port always wins, 1 = round-robin).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 stall_req  in  STAGES  per-stage external stall request (cache/DRAM miss), bit i from stage i.
REQ-009 ex_load  in  1  instruction in ID/EX is a load.
REQ-010 ex_rd  in  5  destination register of that load.
REQ-011 id_rs, id_rt  in  5 each  ID-stage source registers.
REQ-012 id_use_rs, id_use_rt  in  1 each  source actually read.
REQ-013 redirect  in  1  taken branch/jump resolved in ID.
REQ-014 exc_flush  in  1  exception/eret; kill all in-flight instructions.
REQ-015 if_req, mem_req  in  1 each  fetch and data requests to the shared memory port.
REQ-016 stall  out  STAGES  hold pipeline register i.
REQ-017 flush  out  STAGES  clear register i to a bubble (bit 0 always 0).
REQ-018 grant_if, grant_mem  out  1 each  shared-port grant, one-hot or zero.
REQ-019 stall_cycles  out  32  saturating count of cycles with stall[0]=1.

Function
REQ-020 Stall SHALL propagate upstream: any source stalling register j SHALL set stall[0..j].
REQ-021 Bubble: where stall[j]=1 and stall[j+1]=0, flush[j+1] SHALL be 1 in the same cycle.
REQ-022 External stall_req[i] SHALL stall registers 0..i combinationally, zero latency.
REQ-023 Load-use hit = ex_load & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
REQ-024 On hit, bubble counter SHALL load LU_BUBBLES-1; registers 0..1 stall while hit or counter!=0; counter decrements per unstalled cycle.
REQ-025 Counter SHALL freeze (not decrement) while any stall_req bit at index >=2 is set.
REQ-026 Arbiter FSM states: IDLE, IF_OWN, MEM_OWN; one request -> its owner state, granted same cycle; none -> IDLE.
REQ-027 Conflict (if_req & mem_req): ARB_MODE 0 grants mem; ARB_MODE 1 grants the port not granted on the previous conflict (last-grant register, initial IF so first conflict grants mem).
REQ-028 IF losing SHALL stall register 0 and flush register 1; mem losing SHALL stall registers 0..MEM_STAGE and flush MEM_STAGE+1 (if it exists).
REQ-029 redirect SHALL flush register 1 only when stall[1]=0; while stall[1]=1 it SHALL be ignored (ID holds and re-presents it).
REQ-030 exc_flush SHALL dominate: flush[1..STAGES-1]=1, stall=0, grants 0, bubble counter cleared, FSM -> IDLE next edge.
REQ-031 A flushed register SHALL never also be stalled; flush has priority only under exc_flush, otherwise REQ-021 ordering holds.
REQ-032 stall_cycles SHALL increment each cycle stall[0]=1 and hold at 0xFFFF_FFFF.

Reset
REQ-033 While rst_n=0: stall, flush, grants = 0; counter = 0; FSM = IDLE; last-grant = IF; stall_cycles = 0.
REQ-034 Reset assertion mid-stall SHALL drop all stalls immediately; release SHALL be synchronous to the next clk edge.

Structure
REQ-035 FSM state encoding and ARB_MODE constants SHALL live in the shared CPU package.
REQ-036 The arbiter SHALL be one sub-module, mem_port_arb; the rest stays in hazard_ctrl.

Verification
REQ-037 stall_req=5'b01000 one cycle -> stall=5'b01111, flush=5'b10000, stall_cycles +1.
REQ-038 ex_load=1, ex_rd=8, id_rs=8, id_use_rs=1, LU_BUBBLES=2 -> stall=5'b00011, flush[2]=1 for 2 cycles, then all 0.
REQ-039 ARB_MODE=1, if_req=mem_req=1 for 3 cycles -> grants mem, if, mem; flush[1]=1 on cycles 1 and 3, flush[4]=1 on cycle 2.
REQ-040 redirect=1 with load-use hit -> flush[1]=0; hit clears next cycle, redirect held -> flush[1]=1.
REQ-041 exc_flush=1 during stall_req=5'b00100 and counter=1 -> flush=5'b11110, stall=0; next cycle counter=0, FSM IDLE.
REQ-042 rst_n low mid-conflict -> all outputs 0 at once; stall_cycles preset 0xFFFF_FFFE, 3 stall cycles -> 0xFFFF_FFFF.
